strobe_window_averager: RTL and testbench

//  Successor to the fixed 2-of-10 strobe averager. Counts rising edges of an event strobe in

---
 rtl/strobe_window_averager_pkg.sv | 19 +
 rtl/strobe_window_averager_edge_det.sv | 26 ++
 rtl/strobe_window_averager.sv | 149 ++++++++++++++
 tb/tb_strobe_window_averager.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/strobe_window_averager_pkg.sv
// Shared types and elaboration-time helpers for the strobe window averager.
package avg_pkg;

    typedef enum logic [1:0] {S_ACC, S_OUT, S_SKIP} state_t;

    function automatic int acc_w_f(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    // A one-event window still needs a 1-bit counter port.
    function automatic int cw_f(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

    function automatic bit params_ok(input int log2_n, input int period, input int sync_stages);
        return (log2_n >= 0) && (period >= (1 << log2_n)) && (sync_stages >= 2);
    endfunction

endpackage

// File: rtl/strobe_window_averager_edge_det.sv
// Synchroniser chain on an asynchronous strobe followed by a one-cycle rising-edge pulse.
module strobe_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    output logic strobe_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_q_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            sync_q_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], strobe_in};
            sync_q_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe_rise = sync_q[SYNC_STAGES-1] & ~sync_q_d;

endmodule

// File: rtl/strobe_window_averager.sv
// Windowed strobe averager: mean of the first 2**LOG2_N samples of every PERIOD-event window.
// Optional min/max outputs are built when AVG_MINMAX_EN is defined.
module strobe_window_averager
    import avg_pkg::*;
#(
    parameter  int DATA_W      = 12,
    parameter  int LOG2_N      = 1,
    parameter  int PERIOD      = 10,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = cw_f(PERIOD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
`ifdef AVG_MINMAX_EN
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
`endif
    output logic [CW-1:0]     win_cnt
);

    localparam int          ACC_W    = acc_w_f(DATA_W, LOG2_N);
    localparam int          N        = 1 << LOG2_N;
    localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] LAST_S = CW'(N - 1);
    localparam bit          HAS_SKIP = (PERIOD > N);

    if (!params_ok(LOG2_N, PERIOD, SYNC_STAGES)) begin : g_bad_params
        $error("strobe_window_averager: need PERIOD >= 2**LOG2_N and SYNC_STAGES >= 2");
    end

    logic              strobe_rise;
    logic              ev;
    state_t            state, state_d;
    logic [ACC_W-1:0]  acc, acc_d;
    logic [CW-1:0]     win_d, win_inc;
    logic              out_ld;
    logic [ACC_W-1:0]  data_x;

    strobe_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe_in   (strobe_in),
        .strobe_rise (strobe_rise)
    );

    assign ev      = strobe_rise & en & ~clr;
    assign win_inc = (win_cnt == LAST) ? '0 : win_cnt + CW'(1);
    assign data_x  = ACC_W'(data_in);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_ACC;
        else        state <= state_d;
    end

    // S_OUT always completes in one cycle, even with en low: publishing the result is not an event.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        win_d   = win_cnt;
        out_ld  = 1'b0;
        if (clr) begin
            state_d = S_ACC;
            acc_d   = '0;
            win_d   = '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (ev) begin
                        acc_d = acc + data_x;
                        win_d = win_inc;
                        if (win_cnt == LAST_S) state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    out_ld  = 1'b1;
                    acc_d   = '0;
                    state_d = HAS_SKIP ? S_SKIP : S_ACC;
                    if (ev) begin
                        win_d = win_inc;
                        if (!HAS_SKIP)            acc_d   = data_x;
                        else if (win_cnt == LAST) state_d = S_ACC;
                    end
                end
                S_SKIP: begin
                    if (ev) begin
                        win_d = win_inc;
                        if (win_cnt == LAST) state_d = S_ACC;
                    end
                end
                default: state_d = S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            win_cnt   <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            acc       <= acc_d;
            win_cnt   <= win_d;
            avg_valid <= out_ld;
            if (out_ld) avg_out <= acc[ACC_W-1:LOG2_N];
        end
    end

`ifdef AVG_MINMAX_EN
    logic [DATA_W-1:0] run_min, run_max, run_min_d, run_max_d;

    // Running extremes restart at each S_OUT; a sample-0 event in S_OUT seeds the next window.
    always_comb begin
        run_min_d = run_min;
        run_max_d = run_max;
        if (clr || state == S_OUT) begin
            run_min_d = '1;
            run_max_d = '0;
        end
        if (ev && (state == S_ACC || (state == S_OUT && !HAS_SKIP))) begin
            if (data_in < run_min_d) run_min_d = data_in;
            if (data_in > run_max_d) run_max_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_min <= '1;
            run_max <= '0;
            min_out <= '1;
            max_out <= '0;
        end else begin
            run_min <= run_min_d;
            run_max <= run_max_d;
            if (out_ld) begin
                min_out <= run_min;
                max_out <= run_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_strobe_window_averager.sv
// Directed bench for strobe_window_averager; min/max instance is built when AVG_MINMAX_EN is defined.
module tb_strobe_window_averager;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, strobe_in, strobe2;
    logic [11:0] data_in, data2;
    logic [11:0] avg_out, avg_out2;
    logic        avg_valid, avg_valid2;
    logic [3:0]  win_cnt;
    logic [0:0]  win_cnt2;
    int          checks = 0;
    int          errors = 0;
    int          vcnt = 0;
    int          vcnt2 = 0;
    logic [11:0] last_avg = '0;
    logic [11:0] q2 [$];

    always #5 clk = ~clk;

`ifdef AVG_MINMAX_EN
    logic [11:0] min_out, max_out, min_out2, max_out2, avg_out3, min_out3, max_out3;
    logic        avg_valid3, en3;
    logic [3:0]  win_cnt3;
    int          vcnt3 = 0;
    logic [11:0] last_avg3 = '0, last_min3 = '0, last_max3 = '0;
`endif

    strobe_window_averager dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .strobe_in(strobe_in),
        .data_in(data_in), .avg_out(avg_out), .avg_valid(avg_valid),
`ifdef AVG_MINMAX_EN
        .min_out(min_out), .max_out(max_out),
`endif
        .win_cnt(win_cnt)
    );

    strobe_window_averager #(.PERIOD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .strobe_in(strobe2),
        .data_in(data2), .avg_out(avg_out2), .avg_valid(avg_valid2),
`ifdef AVG_MINMAX_EN
        .min_out(min_out2), .max_out(max_out2),
`endif
        .win_cnt(win_cnt2)
    );

`ifdef AVG_MINMAX_EN
    strobe_window_averager #(.LOG2_N(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .clr(clr), .strobe_in(strobe_in),
        .data_in(data_in), .avg_out(avg_out3), .avg_valid(avg_valid3),
        .min_out(min_out3), .max_out(max_out3), .win_cnt(win_cnt3)
    );
`endif

    // Result monitors sample 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (avg_valid) begin vcnt++; last_avg = avg_out; end
        if (avg_valid2) begin vcnt2++; q2.push_back(avg_out2); end
`ifdef AVG_MINMAX_EN
        if (avg_valid3) begin
            vcnt3++; last_avg3 = avg_out3; last_min3 = min_out3; last_max3 = max_out3;
        end
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One event on the shared strobe; data held across the whole detection window.
    task automatic ev(input logic [11:0] d);
        @(negedge clk); data_in = d; strobe_in = 1'b1;
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        int v0;
        logic [11:0] d5 [4];
        d5[0] = 12'd10; d5[1] = 12'd20; d5[2] = 12'd30; d5[3] = 12'd40;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; strobe_in = 1'b0; strobe2 = 1'b0;
        data_in = '0; data2 = '0;
`ifdef AVG_MINMAX_EN
        en3 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset avg_out", 32'(avg_out), 0);
        chk("reset avg_valid", 32'(avg_valid), 0);
        chk("reset win_cnt", 32'(win_cnt), 0);
`ifdef AVG_MINMAX_EN
        chk("reset min_out", 32'(min_out), 32'hFFF);
        chk("reset max_out", 32'(max_out), 0);
`endif
        rst_n = 1'b1;

        // Window of 10: mean of events 0 and 1 only.
        ev(12'd100);
        chk("t1 win after ev0", 32'(win_cnt), 1);
        ev(12'd201);
        chk("t1 pulse count", 32'(vcnt), 1);
        chk("t1 avg", 32'(last_avg), 150);
        chk("t1 win after ev1", 32'(win_cnt), 2);
`ifdef AVG_MINMAX_EN
        chk("t1 min", 32'(min_out), 100);
        chk("t1 max", 32'(max_out), 201);
`endif
        for (int i = 2; i < 10; i++) ev(12'd7);
        chk("t1 no pulse ev2..9", 32'(vcnt), 1);
        chk("t1 win wrapped", 32'(win_cnt), 0);
        ev(12'd7);
        chk("t1 new window win", 32'(win_cnt), 1);
        chk("t1 held avg", 32'(avg_out), 150);

        // Full-scale samples and truncation.
        clr_pulse();
        chk("t2 clr win", 32'(win_cnt), 0);
        ev(12'd4095); ev(12'd4095);
        chk("t2 max avg", 32'(last_avg), 4095);
        clr_pulse();
        ev(12'd0); ev(12'd1);
        chk("t2 trunc avg", 32'(last_avg), 0);
        chk("t2 pulse count", 32'(vcnt), 3);

        // en low freezes the window.
        clr_pulse();
        ev(12'd50);
        en = 1'b0;
        ev(12'd999); ev(12'd999); ev(12'd999);
        chk("t3 win frozen", 32'(win_cnt), 1);
        chk("t3 no pulse", 32'(vcnt), 3);
        en = 1'b1;
        ev(12'd70);
        chk("t3 avg", 32'(last_avg), 60);
        chk("t3 win", 32'(win_cnt), 2);

        // clr wins over a coincident event.
        clr_pulse();
        ev(12'd11);
        v0 = vcnt;
        clr = 1'b1;
        ev(12'd99);
        clr = 1'b0;
        chk("t4 win after clr", 32'(win_cnt), 0);
        chk("t4 no pulse", 32'(vcnt), v0);
        chk("t4 avg kept", 32'(avg_out), 60);
        ev(12'd10); ev(12'd30);
        chk("t4 avg", 32'(last_avg), 20);
        chk("t4 one pulse", 32'(vcnt), v0 + 1);

        // PERIOD == N instance, events every 3 cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); strobe2 = 1'b1; data2 = d5[i];
            @(negedge clk); strobe2 = 1'b0;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("t5 pulse count", 32'(vcnt2), 2);
        if (q2.size() >= 2) begin
            chk("t5 first avg", 32'(q2[0]), 15);
            chk("t5 second avg", 32'(q2[1]), 35);
        end
        chk("t5 win", 32'(win_cnt2), 0);

`ifdef AVG_MINMAX_EN
        clr_pulse();
        en3 = 1'b1;
        ev(12'd7); ev(12'd3); ev(12'd9); ev(12'd5);
        en3 = 1'b0;
        chk("t6 pulse count", 32'(vcnt3), 1);
        chk("t6 avg", 32'(last_avg3), 6);
        chk("t6 min", 32'(last_min3), 3);
        chk("t6 max", 32'(last_max3), 9);
`endif

        // Reset mid-window discards the partial window.
        clr_pulse();
        ev(12'd5);
        chk("t7 win before rst", 32'(win_cnt), 1);
        v0 = vcnt;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("t7 rst avg", 32'(avg_out), 0);
        chk("t7 rst valid", 32'(avg_valid), 0);
        chk("t7 rst win", 32'(win_cnt), 0);
        rst_n = 1'b1;
        ev(12'd9);
        chk("t7 win after rst", 32'(win_cnt), 1);
        chk("t7 no pulse", 32'(vcnt), v0);
        chk("t7 avg still 0", 32'(avg_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
